// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator with registered sync, blanking, colour and frame-start outputs
// Ports:
//   clk             pixel clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   i_vga_data      {R,G,B} from video memory for the current o_h_addr/o_v_addr
//   o_h_addr        visible column, combinational, 0 outside the active region
//   o_v_addr        visible row, combinational, 0 outside the active region
//   o_hsync         registered horizontal sync, active low
//   o_vsync         registered vertical sync, active low
//   o_blank_n       registered display enable
//   o_vga_r/g/b     registered colour, forced to 0 while blanked
//   o_frame_start   registered one-cycle pulse on the first visible pixel of a frame
module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_vga_data,
    output logic [9:0]  o_h_addr,
    output logic [9:0]  o_v_addr,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank_n,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] H_SYN  = 10'(H_SYNC);
    localparam logic [9:0] V_SYN  = 10'(V_SYNC);
    localparam logic [9:0] HA_BEG = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] VA_BEG = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] HA_END = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] VA_END = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic [9:0] r_h_cnt, r_v_cnt;
    logic       w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_vis;

    assign w_h_wrap = r_h_cnt == H_LAST;
    assign w_v_wrap = r_v_cnt == V_LAST;
    assign w_h_act  = (r_h_cnt >= HA_BEG) && (r_h_cnt < HA_END);
    assign w_v_act  = (r_v_cnt >= VA_BEG) && (r_v_cnt < VA_END);
    assign w_vis    = w_h_act && w_v_act;
    assign o_h_addr = w_h_act ? r_h_cnt - HA_BEG : '0;
    assign o_v_addr = w_v_act ? r_v_cnt - VA_BEG : '0;

    // Outputs sample the counter state of the current cycle, so they lag the addresses by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_blank_n     <= 1'b0;
            {o_vga_r, o_vga_g, o_vga_b} <= '0;
            o_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
            if (w_h_wrap)
                r_v_cnt   <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
            o_hsync       <= !(r_h_cnt < H_SYN);
            o_vsync       <= !(r_v_cnt < V_SYN);
            o_blank_n     <= w_vis;
            {o_vga_r, o_vga_g, o_vga_b} <= w_vis ? i_vga_data : '0;
            o_frame_start <= (r_h_cnt == HA_BEG) && (r_v_cnt == VA_BEG);
        end
    end
endmodule
